// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data-memory responder with programmable wait
// states, little-endian sub-word lanes, extension, and alignment/range checks.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ByteSel,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        AddrError
);
    localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] waitCnt;

    logic [31:0] addrQ;
    logic [31:0] writeDataQ;
    logic        writeQ;
    logic        unsignedQ;
    logic [1:0]  byteSelQ;

    logic [31:0] curAddr;
    logic [31:0] curWriteData;
    logic        curWrite;
    logic        curUnsigned;
    logic [1:0]  curByteSel;

    logic             accept;
    logic             enterResp;
    logic             isHalf;
    logic             isByte;
    logic             addrErr;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      memWord;
    logic [31:0]      laneWord;
    logic [31:0]      loadData;
    logic [31:0]      storeData;
    logic [3:0]       laneEn;

    logic [31:0] mem [DEPTH_WORDS];

    // Request decode; in IDLE the live inputs are used so a zero-wait request
    // can commit/read on its own acceptance edge, otherwise the latched copy.
    always_comb begin
        accept    = (state == IDLE) && ReqReady && ReqValid;
        enterResp = (accept && (WAIT_STATES == 0)) ||
                    ((state == WAIT) && (waitCnt == CNT_ONE));

        if (state == IDLE) begin
            curAddr      = Address;
            curWriteData = WriteData;
            curWrite     = ReqWrite;
            curUnsigned  = Unsigned;
            curByteSel   = ByteSel;
        end else begin
            curAddr      = addrQ;
            curWriteData = writeDataQ;
            curWrite     = writeQ;
            curUnsigned  = unsignedQ;
            curByteSel   = byteSelQ;
        end

        isHalf  = (curByteSel == 2'b01);
        isByte  = (curByteSel == 2'b10);
        addrErr = ({2'b00, curAddr[31:2]} >= DEPTH_WORDS) ||
                  (!isHalf && !isByte && (curAddr[1:0] != 2'b00)) ||
                  (isHalf && curAddr[0]);

        wordIdx  = curAddr[IDX_W+1:2];
        memWord  = mem[wordIdx];
        laneWord = memWord >> {curAddr[1:0], 3'b000};

        if (isHalf) begin
            loadData  = curUnsigned ? {16'h0000, laneWord[15:0]}
                                    : {{16{laneWord[15]}}, laneWord[15:0]};
            storeData = {2{curWriteData[15:0]}};
            laneEn    = curAddr[1] ? 4'b1100 : 4'b0011;
        end else if (isByte) begin
            loadData  = curUnsigned ? {24'h000000, laneWord[7:0]}
                                    : {{24{laneWord[7]}}, laneWord[7:0]};
            storeData = {4{curWriteData[7:0]}};
            laneEn    = 4'b0001 << curAddr[1:0];
        end else begin
            loadData  = memWord;
            storeData = curWriteData;
            laneEn    = 4'b1111;
        end
    end

    // Capture the request on acceptance so later input changes are ignored
    always_ff @(posedge Clock) begin
        if (accept) begin
            addrQ      <= Address;
            writeDataQ <= WriteData;
            writeQ     <= ReqWrite;
            unsignedQ  <= Unsigned;
            byteSelQ   <= ByteSel;
        end
    end

    // Store commit on the edge entering RESP; a reset on that edge drops it
    always_ff @(posedge Clock) begin
        if (Reset && enterResp && curWrite && !addrErr) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (laneEn[lane]) begin
                    mem[wordIdx][8*lane +: 8] <= storeData[8*lane +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            ReqReady  <= 1'b0;
            RespValid <= 1'b0;
            ReadData  <= '0;
            AddrError <= 1'b0;
        end else begin
            RespValid <= enterResp;
            AddrError <= enterResp && addrErr;
            ReadData  <= (enterResp && !curWrite && !addrErr) ? loadData : '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                        waitCnt  <= CNT_LOAD;
                        ReqReady <= 1'b0;
                    end else begin
                        ReqReady <= 1'b1;
                    end
                end
                WAIT: begin
                    if (waitCnt == CNT_ONE) begin
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt - CNT_ONE;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    ReqReady <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    ReqReady <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus randomized checks of data_mem_responder
// against a byte-array reference model (one instance with 2 wait states, one
// with none).
module tb_data_mem_responder;
    localparam int unsigned WS    = 2;
    localparam int unsigned DEPTH = 1024;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite, Unsigned;
    logic [1:0]  ByteSel;
    logic [31:0] Address, WriteData, ReadData;
    logic        RespValid, AddrError;

    logic        rv0, rdy0, wr0, un0, resp0, err0;
    logic [1:0]  bs0;
    logic [31:0] addr0, wd0, rd0;

    int nCmp = 0;
    int nBad = 0;

    bit [7:0] refMem [0:63];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ByteSel(ByteSel), .Unsigned(Unsigned),
        .Address(Address), .WriteData(WriteData), .RespValid(RespValid),
        .ReadData(ReadData), .AddrError(AddrError)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .ReqValid(rv0), .ReqReady(rdy0),
        .ReqWrite(wr0), .ByteSel(bs0), .Unsigned(un0),
        .Address(addr0), .WriteData(wd0), .RespValid(resp0),
        .ReadData(rd0), .AddrError(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nBad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected response from access size, alignment and little-endian bytes
    function automatic void modelResp(input bit wr, input logic [1:0] bs, input bit un,
                                      input logic [31:0] a, output bit err,
                                      output logic [31:0] data);
        int unsigned size;
        longint unsigned v;
        size = (bs == 2'b01) ? 2 : (bs == 2'b10) ? 1 : 4;
        err  = ((a / 4) >= DEPTH) || ((a % size) != 0);
        data = '0;
        v    = 0;
        if (!err && !wr) begin
            for (int i = int'(size) - 1; i >= 0; i--) v = v * 256 + refMem[a + i];
            if (!un && size < 4 && v >= (64'd1 << (8 * size - 1)))
                v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
            data = v[31:0];
        end
    endfunction

    function automatic void modelStore(input logic [1:0] bs, input logic [31:0] a,
                                       input logic [31:0] wd);
        int unsigned size;
        logic [31:0] t;
        size = (bs == 2'b01) ? 2 : (bs == 2'b10) ? 1 : 4;
        for (int unsigned i = 0; i < size; i++) begin
            t = wd >> (8 * i);
            refMem[a + i] = t[7:0];
        end
    endfunction

    // One request on the WS instance; bench phase is always #1 after a posedge
    task automatic txn(input bit wr, input logic [1:0] bs, input bit un,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit expErr;
        logic [31:0] expData;
        int n;
        modelResp(wr, bs, un, a, expErr, expData);
        n = 0;
        while (ReqReady !== 1'b1 && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        chk({tag, ".ready"}, 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqWrite = wr; ByteSel = bs; Unsigned = un;
        Address = a; WriteData = wd;
        @(posedge Clock); #1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'($urandom);
        ByteSel   = 2'($urandom);
        Unsigned  = 1'($urandom);
        Address   = $urandom;
        WriteData = $urandom;
        for (int i = 0; i < int'(WS); i++) begin
            chk({tag, ".early"}, 32'(RespValid), 32'd0);
            chk({tag, ".earlyData"}, ReadData, 32'd0);
            @(posedge Clock); #1;
        end
        chk({tag, ".resp"}, 32'(RespValid), 32'd1);
        chk({tag, ".err"}, 32'(AddrError), 32'(expErr));
        if (!wr || expErr) chk({tag, ".data"}, ReadData, expData);
        if (wr && !expErr) modelStore(bs, a, wd);
        @(posedge Clock); #1;
        chk({tag, ".respDrop"}, 32'(RespValid), 32'd0);
        chk({tag, ".dataIdle"}, ReadData, 32'd0);
        chk({tag, ".errIdle"}, 32'(AddrError), 32'd0);
    endtask

    // Directed steps followed by randomized traffic
    initial begin
        Reset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ByteSel = 2'b00;
        Unsigned = 1'b0; Address = '0; WriteData = '0;
        rv0 = 1'b0; wr0 = 1'b0; bs0 = 2'b00; un0 = 1'b0; addr0 = '0; wd0 = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            chk("rst.ready", 32'(ReqReady), 32'd0);
            chk("rst.resp", 32'(RespValid), 32'd0);
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk("post.ready", 32'(ReqReady), 32'd1);
        chk("post.resp", 32'(RespValid), 32'd0);
        chk("post.data", ReadData, 32'd0);
        chk("post.err", 32'(AddrError), 32'd0);
        chk("post.ready0", 32'(rdy0), 32'd1);

        txn(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, "stW10");
        txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "ldW10");
        txn(1'b1, 2'b10, 1'b0, 32'h11, 32'h00000080, "stB11");
        txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "ldW10b");
        txn(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, "ldB11s");
        txn(1'b0, 2'b10, 1'b1, 32'h11, 32'h0, "ldB11u");
        txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "ldH12s");
        txn(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, "ldH13err");
        txn(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "ldW12err");
        txn(1'b1, 2'b00, 1'b0, 32'h0, 32'h12345678, "stW00");
        txn(1'b1, 2'b00, 1'b0, 32'h1000, 32'hFFFFFFFF, "stWoor");
        txn(1'b0, 2'b00, 1'b0, 32'h0FFC, 32'h0, "ldWlast");
        txn(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, "ldW00");

        // Reset lands one cycle after a store is accepted
        txn(1'b1, 2'b00, 1'b0, 32'h20, 32'h0BADF00D, "stW20");
        ReqValid = 1'b1; ReqWrite = 1'b1; ByteSel = 2'b00; Address = 32'h20;
        WriteData = 32'h55AA55AA;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("midRst.resp", 32'(RespValid), 32'd0);
        chk("midRst.ready", 32'(ReqReady), 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            chk("midRst.noResp", 32'(RespValid), 32'd0);
        end
        txn(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, "ldW20");

        for (int w = 0; w < 16; w++) txn(1'b1, 2'b00, 1'b0, 32'(w * 4), $urandom, "init");
        for (int t = 0; t < 80; t++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 + $urandom_range(0, 255);
            else if (sel == 1) a = $urandom | 32'h8000_0000;
            else               a = $urandom_range(0, 63);
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rand");
        end

        // Zero-wait instance: request held high alternates accept/respond
        chk("z.ready", 32'(rdy0), 32'd1);
        rv0 = 1'b1; wr0 = 1'b1; bs0 = 2'b00; addr0 = 32'h4; wd0 = 32'hCAFEF00D;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clock); #1;
            chk("z.resp", 32'(resp0), 32'(i % 2 == 1));
            chk("z.rdy", 32'(rdy0), 32'(i % 2 == 0));
            chk("z.err", 32'(err0), 32'd0);
        end
        wr0 = 1'b0;
        @(posedge Clock); #1;
        rv0 = 1'b0;
        chk("z.ldResp", 32'(resp0), 32'd1);
        chk("z.ldData", rd0, 32'hCAFEF00D);
        @(posedge Clock); #1;
        chk("z.ldDrop", 32'(resp0), 32'd0);
        chk("z.ldIdle", rd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit (observed timeout, expected completion)");
        $fatal(1);
    end
endmodule
